// File: rtl/cpu_pkg.sv
// Shared CPU constants for the general register file: widths, special
// register indices, the PC read offset and small helpers for r15 handling.
package cpu_pkg;

    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 16;
    localparam int ADDR_W     = 4;
    // r15 is not stored; only r0..r14 live in the array
    localparam int NUM_STORED = NUM_REGS - 1;

    localparam logic [ADDR_W-1:0] REG_SP = 4'd13;
    localparam logic [ADDR_W-1:0] REG_LR = 4'd14;
    localparam logic [ADDR_W-1:0] REG_PC = 4'd15;

    localparam logic [DATA_W-1:0] PC_OFFSET = 32'd8;

    // Where a read port takes its operand from, in priority order
    typedef enum logic [1:0] {
        SRC_PC     = 2'd0,
        SRC_BYPASS = 2'd1,
        SRC_ARRAY  = 2'd2
    } rd_src_e;

    // Architectural view of r15 while an instruction sits in decode
    function automatic logic [DATA_W-1:0] pc_read_view(input logic [DATA_W-1:0] pc);
        return pc + PC_OFFSET;
    endfunction

    // Branch targets are word aligned; low two bits are dropped
    function automatic logic [DATA_W-1:0] pc_align(input logic [DATA_W-1:0] value);
        return {value[DATA_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One registered operand read port: picks PC view, same-cycle write bypass
// or stored register, and captures it when the parent accepts a request.
module regfile_read_port
    import cpu_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         capture,
    input  logic [ADDR_W-1:0]            rd_addr,
    input  logic [NUM_STORED*DATA_W-1:0] regs_flat,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [DATA_W-1:0]            pc_in,
    output logic [DATA_W-1:0]            rd_data
);

    rd_src_e           src;
    logic [DATA_W-1:0] stored;
    logic [DATA_W-1:0] next_data;

    // Choose the operand source; r15 wins over the bypass so a branch write
    // never leaks into a PC read
    always_comb begin
        src = SRC_ARRAY;
        if (rd_addr == REG_PC) begin
            src = SRC_PC;
        end else if (wr_en && (wr_addr == rd_addr)) begin
            src = SRC_BYPASS;
        end
    end

    // Pull the addressed entry out of the flattened array
    always_comb begin
        stored = '0;
        for (int i = 0; i < NUM_STORED; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                stored = regs_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    // Operand mux driven by the source select
    always_comb begin
        next_data = stored;
        case (src)
            SRC_PC:     next_data = pc_read_view(pc_in);
            SRC_BYPASS: next_data = wr_data;
            default:    next_data = stored;
        endcase
    end

    // Output register: loads on an accepted request, otherwise holds
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_data <= '0;
        end else if (capture) begin
            rd_data <= next_data;
        end
    end

endmodule

// File: rtl/register_file.sv
// ARM general register file: 15 stored registers plus the r15 PC view,
// one write port, two registered read ports and a branch pulse on r15 writes.
module register_file
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    input  logic              stall,
    input  logic [DATA_W-1:0] pc_in,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              pc_wr_en,
    output logic [DATA_W-1:0] pc_wr_data
);

    logic [NUM_STORED-1:0][DATA_W-1:0] regs;
    logic                              capture;
    logic                              pc_write;

    assign capture  = rd_req && !stall;
    assign pc_write = wr_en && (wr_addr == REG_PC);

    // Register array write; r15 never matches an array slot so it is skipped
    always_ff @(posedge clk) begin
        if (!reset) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < NUM_STORED; i++) begin
                if (wr_en && (wr_addr == ADDR_W'(i))) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Valid flag follows accepted requests and freezes while stalled
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid <= 1'b0;
        end else if (!stall) begin
            rd_valid <= rd_req;
        end
    end

    // r15 writes become a one-cycle branch request to fetch, ignoring stall
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_wr_en   <= 1'b0;
            pc_wr_data <= '0;
        end else begin
            pc_wr_en <= pc_write;
            if (pc_write) begin
                pc_wr_data <= pc_align(wr_data);
            end
        end
    end

    regfile_read_port u_port_a (
        .clk       (clk),
        .reset     (reset),
        .capture   (capture),
        .rd_addr   (rd_addr_a),
        .regs_flat (regs),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pc_in     (pc_in),
        .rd_data   (rd_data_a)
    );

    regfile_read_port u_port_b (
        .clk       (clk),
        .reset     (reset),
        .capture   (capture),
        .rd_addr   (rd_addr_b),
        .regs_flat (regs),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pc_in     (pc_in),
        .rd_data   (rd_data_b)
    );

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: directed vector table with hand-computed
// expectations, then randomized cycles against a behavioural model.
module tb_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_req;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic        stall;
    logic [31:0] pc_in;
    logic        rd_valid;
    logic [31:0] rd_data_a;
    logic [31:0] rd_data_b;
    logic        pc_wr_en;
    logic [31:0] pc_wr_data;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [31:0] m_regs [0:14];
    logic        m_valid;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic        m_pcen;
    logic [31:0] m_pcdata;

    typedef struct {
        logic        rst;
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        req;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic        stl;
        logic [31:0] pc;
        logic        e_valid;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic        e_pcen;
        logic [31:0] e_pcdata;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs [NVEC];

    register_file dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_req     (rd_req),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .stall      (stall),
        .pc_in      (pc_in),
        .rd_valid   (rd_valid),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .pc_wr_en   (pc_wr_en),
        .pc_wr_data (pc_wr_data)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic we, input logic [3:0] wa,
                                input logic [31:0] wd, input logic req, input logic [3:0] ra,
                                input logic [3:0] rb, input logic stl, input logic [31:0] pc,
                                input logic ev, input logic [31:0] ea, input logic [31:0] eb,
                                input logic epe, input logic [31:0] epd);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.req = req; v.ra = ra; v.rb = rb;
        v.stl = stl; v.pc = pc; v.e_valid = ev; v.e_a = ea; v.e_b = eb; v.e_pcen = epe;
        v.e_pcdata = epd;
        return v;
    endfunction

    // Operand as seen by a read of register idx with the current inputs
    function automatic logic [31:0] modelRead(input logic [3:0] idx);
        if (idx == 4'd15) return pc_in + 32'd8;
        if (wr_en && wr_addr == idx) return wr_data;
        return m_regs[idx];
    endfunction

    // Advance the model by one clock edge using the inputs currently driven
    task automatic modelStep();
        logic [31:0] na, nb;
        if (!reset) begin
            for (int i = 0; i < 15; i++) m_regs[i] = 32'h0;
            m_valid = 1'b0; m_a = 32'h0; m_b = 32'h0; m_pcen = 1'b0; m_pcdata = 32'h0;
        end else begin
            na = modelRead(rd_addr_a);
            nb = modelRead(rd_addr_b);
            if (!stall) begin
                m_valid = rd_req;
                if (rd_req) begin
                    m_a = na;
                    m_b = nb;
                end
            end
            m_pcen = wr_en && (wr_addr == 4'd15);
            if (m_pcen) m_pcdata = wr_data & 32'hFFFF_FFFC;
            if (wr_en && wr_addr != 4'd15) m_regs[wr_addr] = wr_data;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic we, input logic [3:0] wa,
                                 input logic [31:0] wd, input logic req, input logic [3:0] ra,
                                 input logic [3:0] rb, input logic stl, input logic [31:0] pc);
        reset = rst; wr_en = we; wr_addr = wa; wr_data = wd; rd_req = req;
        rd_addr_a = ra; rd_addr_b = rb; stall = stl; pc_in = pc;
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        // Directed vectors; expected outputs are those seen after the edge
        vecs[0]  = mk(0,1,4'd3,32'h11111111,1,4'd3,4'd15,0,32'h100,      0,32'h0,32'h0,0,32'h0);
        vecs[1]  = mk(0,1,4'd3,32'h11111111,1,4'd3,4'd15,0,32'h100,      0,32'h0,32'h0,0,32'h0);
        vecs[2]  = mk(1,0,4'd0,32'h0,       1,4'd3,4'd0, 0,32'h0,        1,32'h0,32'h0,0,32'h0);
        vecs[3]  = mk(1,1,4'd5,32'hDEADBEEF,0,4'd0,4'd0, 0,32'h0,        0,32'h0,32'h0,0,32'h0);
        vecs[4]  = mk(1,0,4'd0,32'h0,       1,4'd5,4'd3, 0,32'h0,        1,32'hDEADBEEF,32'h0,0,32'h0);
        vecs[5]  = mk(1,1,4'd7,32'h12345678,1,4'd7,4'd7, 0,32'h0,        1,32'h12345678,32'h12345678,0,32'h0);
        vecs[6]  = mk(1,0,4'd0,32'h0,       1,4'd15,4'd5,0,32'h1000,     1,32'h1008,32'hDEADBEEF,0,32'h0);
        vecs[7]  = mk(1,0,4'd0,32'h0,       1,4'd15,4'd15,0,32'hFFFFFFFC,1,32'h4,32'h4,0,32'h0);
        vecs[8]  = mk(1,1,4'd15,32'h2003,   1,4'd15,4'd7,0,32'h1000,     1,32'h1008,32'h12345678,1,32'h2000);
        vecs[9]  = mk(1,1,4'd15,32'hFFFFFFFF,0,4'd0,4'd0,0,32'h1000,     0,32'h1008,32'h12345678,1,32'hFFFFFFFC);
        vecs[10] = mk(1,0,4'd0,32'h0,       0,4'd0,4'd0, 0,32'h1000,     0,32'h1008,32'h12345678,0,32'hFFFFFFFC);
        vecs[11] = mk(1,0,4'd0,32'h0,       1,4'd5,4'd7, 0,32'h1000,     1,32'hDEADBEEF,32'h12345678,0,32'hFFFFFFFC);
        vecs[12] = mk(1,1,4'd5,32'hCAFEF00D,1,4'd3,4'd15,1,32'h1000,     1,32'hDEADBEEF,32'h12345678,0,32'hFFFFFFFC);
        vecs[13] = mk(1,0,4'd0,32'h0,       1,4'd5,4'd5, 1,32'h1000,     1,32'hDEADBEEF,32'h12345678,0,32'hFFFFFFFC);
        vecs[14] = mk(1,0,4'd0,32'h0,       1,4'd5,4'd5, 1,32'h1000,     1,32'hDEADBEEF,32'h12345678,0,32'hFFFFFFFC);
        vecs[15] = mk(1,0,4'd0,32'h0,       0,4'd5,4'd5, 0,32'h1000,     0,32'hDEADBEEF,32'h12345678,0,32'hFFFFFFFC);
        vecs[16] = mk(1,0,4'd0,32'h0,       1,4'd5,4'd0, 0,32'h1000,     1,32'hCAFEF00D,32'h0,0,32'hFFFFFFFC);
        vecs[17] = mk(1,0,4'd0,32'h0,       1,4'd5,4'd5, 1,32'h1000,     1,32'hCAFEF00D,32'h0,0,32'hFFFFFFFC);
        vecs[18] = mk(0,1,4'd15,32'h4444,   1,4'd5,4'd5, 1,32'h1000,     0,32'h0,32'h0,0,32'h0);
        vecs[19] = mk(1,0,4'd0,32'h0,       1,4'd5,4'd3, 0,32'h1000,     1,32'h0,32'h0,0,32'h0);

        for (int i = 0; i < 15; i++) m_regs[i] = 32'h0;
        m_valid = 1'b0; m_a = 32'h0; m_b = 32'h0; m_pcen = 1'b0; m_pcdata = 32'h0;

        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_req = 1'b0;
        rd_addr_a = '0; rd_addr_b = '0; stall = 1'b0; pc_in = '0;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].req,
                          vecs[i].ra, vecs[i].rb, vecs[i].stl, vecs[i].pc);
            checkOutput($sformatf("vec%0d rd_valid", i),   {31'h0, rd_valid}, {31'h0, vecs[i].e_valid});
            checkOutput($sformatf("vec%0d rd_data_a", i),  rd_data_a,         vecs[i].e_a);
            checkOutput($sformatf("vec%0d rd_data_b", i),  rd_data_b,         vecs[i].e_b);
            checkOutput($sformatf("vec%0d pc_wr_en", i),   {31'h0, pc_wr_en}, {31'h0, vecs[i].e_pcen});
            checkOutput($sformatf("vec%0d pc_wr_data", i), pc_wr_data,        vecs[i].e_pcdata);
        end

        // Back-to-back r15 writes give back-to-back branch pulses
        applyStimulus(1, 1, 4'd15, 32'h0000_1235, 0, 4'd0, 4'd0, 1, 32'h0);
        checkOutput("b2b pulse1 en",   {31'h0, pc_wr_en}, 32'h1);
        checkOutput("b2b pulse1 data", pc_wr_data,        32'h0000_1234);
        applyStimulus(1, 1, 4'd15, 32'h0000_5678, 0, 4'd0, 4'd0, 1, 32'h0);
        checkOutput("b2b pulse2 en",   {31'h0, pc_wr_en}, 32'h1);
        checkOutput("b2b pulse2 data", pc_wr_data,        32'h0000_5678);
        applyStimulus(1, 0, 4'd0, 32'h0, 0, 4'd0, 4'd0, 0, 32'h0);
        checkOutput("b2b pulse end",   {31'h0, pc_wr_en}, 32'h0);

        // Randomized cycles against the behavioural model
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 49) != 0), $urandom_range(0, 1) == 1,
                          4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) != 0,
                          4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          $urandom_range(0, 3) == 0, $urandom);
            checkOutput("rand rd_valid",   {31'h0, rd_valid}, {31'h0, m_valid});
            checkOutput("rand rd_data_a",  rd_data_a,         m_a);
            checkOutput("rand rd_data_b",  rd_data_b,         m_b);
            checkOutput("rand pc_wr_en",   {31'h0, pc_wr_en}, {31'h0, m_pcen});
            checkOutput("rand pc_wr_data", pc_wr_data,        m_pcdata);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
